i2c_slave: RTL

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_slave.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave.sv
`timescale 1ns/1ps
// i2c_slave: I2C target with a small register file.
//   Write: S, addr+W, reg index, data..., P   (index auto-increments)
//   Read : S, addr+R, data..., P               (starts at current pointer)
// Ports:
//   clk        system clock (>= 8x SCL)
//   rst        synchronous active-low reset
//   scl_in     bus clock, asynchronous
//   sda_in     bus data, asynchronous
//   sda_oe     1 = pull SDA low, 0 = release
//   busy       address-matched transfer in progress
//   wr_strobe  one-clk pulse per byte written into the register file
//   wr_addr    register index of that write
//   wr_data    byte written
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int          NREG       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       busy,
    output logic       wr_strobe,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] ADDR      = 4'd1;
    localparam logic [3:0] ADDR_ACK  = 4'd2;
    localparam logic [3:0] REG       = 4'd3;
    localparam logic [3:0] REG_ACK   = 4'd4;
    localparam logic [3:0] WDATA     = 4'd5;
    localparam logic [3:0] WDATA_ACK = 4'd6;
    localparam logic [3:0] RDATA     = 4'd7;
    localparam logic [3:0] RDATA_ACK = 4'd8;

    // [0],[1] synchronize; [2] is the previous synchronized value for edges
    logic [2:0] scl_s, sda_s;
    logic [3:0] state;
    logic [2:0] cnt;
    logic [6:0] sh;       // first 7 bits received, or remaining read bits
    logic [3:0] ptr;
    logic       rw;
    logic       phase;    // in *_ACK states: the 9th SCL rise has been seen
    logic [7:0] regfile [NREG];

    logic scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] sh_nx;

    assign scl_rise  =  scl_s[1] & ~scl_s[2];
    assign scl_fall  = ~scl_s[1] &  scl_s[2];
    assign start_det =  scl_s[1] & ~sda_s[1] &  sda_s[2];
    assign stop_det  =  scl_s[1] &  sda_s[1] & ~sda_s[2];
    assign sh_nx     = {sh, sda_s[1]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_s     <= '1;
            sda_s     <= '1;
            state     <= IDLE;
            cnt       <= '0;
            sh        <= '0;
            ptr       <= '0;
            rw        <= 1'b0;
            phase     <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            for (int i = 0; i < NREG; i++) regfile[i] <= '0;
        end else begin
            scl_s     <= {scl_s[1:0], scl_in};
            sda_s     <= {sda_s[1:0], sda_in};
            wr_strobe <= 1'b0;
            // bus conditions win over any SCL edge seen in the same clk
            if (start_det) begin
                state  <= ADDR;
                cnt    <= '0;
                sda_oe <= 1'b0;
            end else if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ADDR, REG, WDATA: begin
                        if (scl_rise) begin
                            sh  <= sh_nx[6:0];
                            cnt <= cnt + 3'd1;
                            if (cnt == 3'd7) begin
                                phase <= 1'b0;
                                if (state == ADDR) begin
                                    if (sh == SLAVE_ADDR) begin
                                        state <= ADDR_ACK;
                                        rw    <= sda_s[1];
                                        busy  <= 1'b1;
                                    end else begin
                                        state <= IDLE;
                                        busy  <= 1'b0;
                                    end
                                end else if (state == REG) begin
                                    ptr   <= sh_nx[3:0];
                                    state <= REG_ACK;
                                end else begin
                                    regfile[ptr] <= sh_nx;
                                    wr_strobe    <= 1'b1;
                                    wr_addr      <= ptr;
                                    wr_data      <= sh_nx;
                                    state        <= WDATA_ACK;
                                end
                            end
                        end
                    end
                    ADDR_ACK, REG_ACK, WDATA_ACK: begin
                        if (scl_rise) begin
                            phase <= 1'b1;
                        end else if (scl_fall) begin
                            if (!phase) begin
                                sda_oe <= 1'b1;
                            end else begin
                                phase  <= 1'b0;
                                cnt    <= '0;
                                sda_oe <= 1'b0;
                                if (state == ADDR_ACK && rw) begin
                                    // ACK release and first read bit share this edge
                                    state  <= RDATA;
                                    sh     <= regfile[ptr][6:0];
                                    sda_oe <= ~regfile[ptr][7];
                                end else if (state == ADDR_ACK) begin
                                    state <= REG;
                                end else begin
                                    state <= WDATA;
                                    if (state == WDATA_ACK) ptr <= ptr + 4'd1;
                                end
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            cnt <= cnt + 3'd1;
                            if (cnt == 3'd7) begin
                                state <= RDATA_ACK;
                                phase <= 1'b0;
                            end
                        end else if (scl_fall) begin
                            sda_oe <= ~sh[6];
                            sh     <= {sh[5:0], 1'b0};
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            phase <= 1'b1;
                            ptr   <= ptr + 4'd1;
                            if (sda_s[1]) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else if (scl_fall) begin
                            if (!phase) begin
                                sda_oe <= 1'b0;
                            end else begin
                                state  <= RDATA;
                                cnt    <= '0;
                                phase  <= 1'b0;
                                sh     <= regfile[ptr][6:0];
                                sda_oe <= ~regfile[ptr][7];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
